program_counter_stack: RTL and testbench

//   Parametrised successor to the SAP 4-bit program counter. Holds the current instruction

---
 rtl/program_counter_stack_pkg.sv | 26 ++
 rtl/program_counter_stack_return_stack.sv | 45 ++++
 rtl/program_counter_stack.sv | 95 +++++++++
 tb/tb_program_counter_stack.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/program_counter_stack_pkg.sv
// Shared defaults and op decode for the SAP program counter with hardware return stack.
package program_counter_stack_pkg;

  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_STACK_DEPTH = 4;
  localparam int DEF_RESET_ADDR  = 0;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_INC  = 3'd1,
    OP_LOAD = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_e;

  // One op per cycle; ret > call > load > inc, losers are simply dropped.
  function automatic pc_op_e decode_op(input logic inc, input logic load,
                                       input logic call, input logic ret);
    if (ret)       return OP_RET;
    else if (call) return OP_CALL;
    else if (load) return OP_LOAD;
    else if (inc)  return OP_INC;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/program_counter_stack_return_stack.sv
// LIFO of return addresses; silently ignores push-when-full and pop-when-empty.
module pc_return_stack #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_top;
  logic [W-1:0]    mem [DEPTH];

  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);
  assign sp_top = sp - 1'b1;
  assign dout   = mem[sp_top[IDX_W-1:0]];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // Contents are don't-care after clr, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// SAP program counter: inc / jump / call / ret with a return stack and tri-state W-bus driver.
module program_counter_stack
  import program_counter_stack_pkg::*;
#(
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int unsigned RESET_ADDR  = DEF_RESET_ADDR
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              call,
  input  logic              ret,
  input  logic              pc_out_en,
  output logic [ADDR_W-1:0] out,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  localparam logic [31:0]       RESET_WORD = 32'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] RESET_PC   = RESET_WORD[ADDR_W-1:0];

  pc_op_e            op;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] ret_addr;
  logic              push;
  logic              pop;
  logic              err_set;

  assign op       = decode_op(inc, load, call, ret);
  assign pc_plus1 = pc + 1'b1;

  pc_return_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus1),
    .dout  (ret_addr),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Overflow and underflow leave pc where it is and only raise the sticky error.
  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    unique case (op)
      OP_INC:  pc_next = pc_plus1;
      OP_LOAD: pc_next = load_addr;
      OP_CALL: begin
        if (!stack_full) begin
          push    = 1'b1;
          pc_next = load_addr;
        end else begin
          err_set = 1'b1;
        end
      end
      OP_RET: begin
        if (!stack_empty) begin
          pop     = 1'b1;
          pc_next = ret_addr;
        end else begin
          err_set = 1'b1;
        end
      end
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc        <= RESET_PC;
      stack_err <= 1'b0;
    end else begin
      pc <= pc_next;
      if (err_set) begin
        stack_err <= 1'b1;
      end
    end
  end

  assign out = pc_out_en ? pc : 'z;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack: default instance plus an 8-bit / depth-1 instance.
module tb_program_counter_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: ADDR_W=4, STACK_DEPTH=4, RESET_ADDR=0
  logic       clr, inc, load, call, ret, pc_out_en;
  logic [3:0] load_addr;
  wire  [3:0] out;
  logic [3:0] pc;
  logic       stack_full, stack_empty, stack_err;

  program_counter_stack dut (
    .clk(clk), .clr(clr), .inc(inc), .load(load), .load_addr(load_addr),
    .call(call), .ret(ret), .pc_out_en(pc_out_en), .out(out), .pc(pc),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  // Swept instance: ADDR_W=8, STACK_DEPTH=1, RESET_ADDR=F0
  logic       clr2, inc2, load2, call2, ret2, pc_out_en2;
  logic [7:0] load_addr2;
  wire  [7:0] out2;
  logic [7:0] pc2;
  logic       full2, empty2, err2;

  program_counter_stack #(.ADDR_W(8), .STACK_DEPTH(1), .RESET_ADDR(8'hF0)) dut2 (
    .clk(clk), .clr(clr2), .inc(inc2), .load(load2), .load_addr(load_addr2),
    .call(call2), .ret(ret2), .pc_out_en(pc_out_en2), .out(out2), .pc(pc2),
    .stack_full(full2), .stack_empty(empty2), .stack_err(err2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] e_pc, input logic e_full,
                             input logic e_empty, input logic e_err);
    check({tag, " pc"},    {28'd0, pc}, {28'd0, e_pc});
    check({tag, " full"},  {31'd0, stack_full}, {31'd0, e_full});
    check({tag, " empty"}, {31'd0, stack_empty}, {31'd0, e_empty});
    check({tag, " err"},   {31'd0, stack_err}, {31'd0, e_err});
  endtask

  // Async clr pulse inside the low phase: effect must show before any rising edge.
  task automatic pulse_clr();
    @(negedge clk);
    inc = 0; load = 0; call = 0; ret = 0;
    #2 clr = 1'b1;
    #1 check_state("clr async", 4'h0, 1'b0, 1'b1, 1'b0);
    #1 clr = 1'b0;
  endtask

  task automatic step(input logic i, input logic l, input logic c, input logic r,
                      input logic [3:0] a);
    @(negedge clk);
    inc = i; load = l; call = c; ret = r; load_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic i, input logic l, input logic c, input logic r,
                       input logic [7:0] a);
    @(negedge clk);
    inc2 = i; load2 = l; call2 = c; ret2 = r; load_addr2 = a;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       do_clr;
    logic       inc, load, call, ret;
    logic [3:0] addr;
    logic [3:0] e_pc;
    logic       e_full, e_empty, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic do_clr, input logic i, input logic l,
                              input logic c, input logic r, input logic [3:0] a,
                              input logic [3:0] p, input logic f, input logic e,
                              input logic er);
    vec_t v;
    v.do_clr = do_clr; v.inc = i; v.load = l; v.call = c; v.ret = r; v.addr = a;
    v.e_pc = p; v.e_full = f; v.e_empty = e; v.e_err = er;
    return v;
  endfunction

  initial begin
    clr = 1'b1; inc = 0; load = 0; call = 0; ret = 0; load_addr = '0; pc_out_en = 0;
    clr2 = 1'b1; inc2 = 0; load2 = 0; call2 = 0; ret2 = 0; load_addr2 = '0; pc_out_en2 = 0;

    // Jump, call/ret, nesting/overflow, underflow and priority
    //               clr i  l  c  r  addr   pc   full empty err
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'h3, 4'h3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'hA, 4'hA, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'h3, 4'h3, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'hA, 4'hA, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'hB, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'h2, 4'h2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'h8, 4'h8, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'h9, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'hA, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0, 4'h3, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'h0, 4'h0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'h1, 4'h1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'h2, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'h3, 4'h3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'h4, 4'h4, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'h9, 4'h4, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0, 4'h4, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0, 4'h3, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0, 4'h2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0, 4'h1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'h5, 4'h5, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'h0, 4'h5, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'hC, 4'h5, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 4'h8, 4'h8, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 4'hC, 4'h6, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 4'hE, 4'hE, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 4'h3, 4'h7, 0, 1, 1));

    // Reset held, released mid-cycle
    #3 check_state("reset", 4'h0, 1'b0, 1'b1, 1'b0);
    check("reset2 pc", {24'd0, pc2}, 32'hF0);
    check("reset2 empty", {31'd0, empty2}, 32'd1);
    #9 clr = 1'b0; clr2 = 1'b0;

    // Counting with wrap; bus enable toggled every other cycle
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      inc = 1'b1;
      pc_out_en = i[0];
      @(posedge clk);
      #1;
      check($sformatf("inc %0d pc", i), {28'd0, pc}, 32'((i + 1) % 16));
      if (pc_out_en) check($sformatf("inc %0d out", i), {28'd0, out}, {28'd0, pc});
      else if (pc != 4'h0) check($sformatf("inc %0d out released", i), {31'd0, out !== pc}, 32'd1);
    end
    @(negedge clk);
    pc_out_en = 1'b0;
    inc = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("pre-clr count", {28'd0, pc}, 32'd3);
    pulse_clr();

    foreach (vecs[k]) begin
      if (vecs[k].do_clr) begin
        pulse_clr();
      end else begin
        step(vecs[k].inc, vecs[k].load, vecs[k].call, vecs[k].ret, vecs[k].addr);
        check_state($sformatf("vec %0d", k), vecs[k].e_pc, vecs[k].e_full,
                    vecs[k].e_empty, vecs[k].e_err);
      end
    end
    step(0, 0, 0, 0, 4'h0);

    // Swept instance: wrap at 8 bits, push of pc=FF stores 00, depth-1 overflow
    step2(0, 1, 0, 0, 8'hFF);
    check("p8 load", {24'd0, pc2}, 32'hFF);
    step2(1, 0, 0, 0, 8'h00);
    check("p8 wrap", {24'd0, pc2}, 32'h00);
    step2(0, 1, 0, 0, 8'hFF);
    step2(0, 0, 1, 0, 8'h10);
    check("p8 call pc", {24'd0, pc2}, 32'h10);
    check("p8 full", {31'd0, full2}, 32'd1);
    step2(0, 0, 1, 0, 8'h20);
    check("p8 overflow pc", {24'd0, pc2}, 32'h10);
    check("p8 err", {31'd0, err2}, 32'd1);
    step2(0, 0, 0, 1, 8'h00);
    check("p8 ret pc", {24'd0, pc2}, 32'h00);
    check("p8 empty", {31'd0, empty2}, 32'd1);
    @(negedge clk);
    ret2 = 1'b0;
    pc_out_en2 = 1'b1;
    #1 check("p8 out", {24'd0, out2}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
